// File: rtl/window_3x3.sv
// Sliding 3x3 window former fed by the line buffer taps; gates output to in-image windows.
// Optional `WIN_OUT_REG_EN adds one output register stage (latency 2 instead of 1).
module window_3x3 #(
   parameter int P_DAT_WIDTH  = 8,
   parameter int P_IMG_WIDTH  = 200,
   parameter int P_IMG_HEIGHT = 150
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_valid,
   input  logic                     i_sof,
   input  logic [P_DAT_WIDTH-1:0]   i_data_r0,
   input  logic [P_DAT_WIDTH-1:0]   i_data_r1,
   input  logic [P_DAT_WIDTH-1:0]   i_data_r2,
   output logic                     o_valid,
   output logic [9*P_DAT_WIDTH-1:0] o_win,
   output logic                     o_sof,
   output logic                     o_eol
);

   localparam int DW = P_DAT_WIDTH;
   localparam int CW = $clog2(P_IMG_WIDTH);
   localparam int RW = $clog2(P_IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(P_IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(P_IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [CW-1:0] col_q;
   logic [CW-1:0] pos_col;
   logic [RW-1:0] row_q;
   logic [RW-1:0] pos_row;
   logic          hit;

   // sr_q[r][c]: packed so that element (r,c) sits at window slot 3*r+c
   logic [2:0][2:0][DW-1:0] sr_q;
   logic [2:0][DW-1:0]      tap;

   logic v1_q;
   logic sof1_q;
   logic eol1_q;

   assign tap = {i_data_r0, i_data_r1, i_data_r2};

   always_comb begin
      pos_col = i_sof ? '0 : col_q;
      pos_row = i_sof ? '0 : row_q;
      hit     = i_valid && (pos_col >= COL_TWO)
                && (pos_row >= ROW_TWO);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         col_q <= '0;
         row_q <= '0;
      end else if (i_valid) begin
         if (pos_col == COL_LAST) begin
            col_q <= '0;
            row_q <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
         end else begin
            col_q <= pos_col + 1'b1;
            row_q <= pos_row;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         sr_q <= '0;
      end else if (i_valid) begin
         for (int r = 0; r < 3; r++) begin
            sr_q[r] <= {tap[r], sr_q[r][2], sr_q[r][1]};
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         v1_q   <= 1'b0;
         sof1_q <= 1'b0;
         eol1_q <= 1'b0;
      end else begin
         v1_q   <= hit;
         sof1_q <= hit && (pos_col == COL_TWO)
                   && (pos_row == ROW_TWO);
         eol1_q <= hit && (pos_col == COL_LAST);
      end
   end

`ifdef WIN_OUT_REG_EN
   logic          v2_q;
   logic          sof2_q;
   logic          eol2_q;
   logic [9*DW-1:0] win2_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         v2_q   <= 1'b0;
         sof2_q <= 1'b0;
         eol2_q <= 1'b0;
         win2_q <= '0;
      end else begin
         v2_q   <= v1_q;
         sof2_q <= sof1_q;
         eol2_q <= eol1_q;
         win2_q <= sr_q;
      end
   end

   assign o_valid = v2_q;
   assign o_sof   = sof2_q;
   assign o_eol   = eol2_q;
   assign o_win   = win2_q;
`else
   assign o_valid = v1_q;
   assign o_sof   = sof1_q;
   assign o_eol   = eol1_q;
   assign o_win   = sr_q;
`endif

endmodule

// File: tb/tb_window_3x3.sv
// Directed table-driven bench for window_3x3 at W=5, H=4, DW=8.
// Pixel value is {row,col}; taps are driven as an ideal line buffer would.
module tb_window_3x3;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int DW = 8;
`ifdef WIN_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic        v;
      logic        sof;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [7:0]  d2;
      logic        ev;
      logic        esof;
      logic        eeol;
      logic [71:0] ewin;
      int          tag;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_valid;
   logic        i_sof;
   logic [7:0]  d0;
   logic [7:0]  d1;
   logic [7:0]  d2;
   logic        o_valid;
   logic [71:0] o_win;
   logic        o_sof;
   logic        o_eol;

   int   n_pass = 0;
   int   n_tot  = 0;
   int   n_v    = 0;
   int   n_eol  = 0;
   vec_t vecs[$];

   window_3x3 #(
      .P_DAT_WIDTH (DW),
      .P_IMG_WIDTH (W),
      .P_IMG_HEIGHT(H)
   ) dut (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_valid  (i_valid),
      .i_sof    (i_sof),
      .i_data_r0(d0),
      .i_data_r1(d1),
      .i_data_r2(d2),
      .o_valid  (o_valid),
      .o_win    (o_win),
      .o_sof    (o_sof),
      .o_eol    (o_eol)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic logic [7:0] pix(int r, int c);
      if (r < 0) return 8'h00;
      return 8'((r << 4) | c);
   endfunction

   task automatic chk(string nm, logic [71:0] act,
                      logic [71:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic add_pix(int r, int c, bit sof);
      vec_t t;
      t.v    = 1'b1;
      t.sof  = sof;
      t.d0   = pix(r, c);
      t.d1   = pix(r - 1, c);
      t.d2   = pix(r - 2, c);
      t.ev   = (r >= 2) && (c >= 2);
      t.esof = (r == 2) && (c == 2);
      t.eeol = t.ev && (c == W - 1);
      t.ewin = '0;
      if (t.ev)
         for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
               t.ewin[(3*rr+cc)*8 +: 8] = pix(r-2+rr, c-2+cc);
      t.tag  = r * 16 + c;
      vecs.push_back(t);
   endtask

   task automatic add_idle(int n, bit sof);
      vec_t t;
      t = '{v: 1'b0, sof: sof, d0: 8'hAA, d1: 8'hBB,
            d2: 8'hCC, ev: 1'b0, esof: 1'b0, eeol: 1'b0,
            ewin: '0, tag: -1};
      for (int k = 0; k < n; k++) vecs.push_back(t);
   endtask

   task automatic add_frame(bit sof, bit stall);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            add_pix(r, c, sof && r == 0 && c == 0);
            if (stall && r == 2 && c == 2) begin
               add_idle(3, 1'b0);
               add_idle(1, 1'b1);
               add_idle(3, 1'b0);
            end
         end
   endtask

   task automatic drive(vec_t t);
      i_valid = t.v;
      i_sof   = t.sof;
      d0      = t.d0;
      d1      = t.d1;
      d2      = t.d2;
   endtask

   initial begin
      vec_t idle;
      int   j;
      bit   seen;

      rstn    = 1'b0;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      d0      = '0;
      d1      = '0;
      d2      = '0;
      idle = '{v: 1'b0, sof: 1'b0, d0: 8'h00, d1: 8'h00,
               d2: 8'h00, ev: 1'b0, esof: 1'b0, eeol: 1'b0,
               ewin: '0, tag: -1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 72'(o_valid), 72'd0);
      chk("rst_sof", 72'(o_sof), 72'd0);
      chk("rst_eol", 72'(o_eol), 72'd0);
      chk("rst_win", o_win, 72'd0);
      rstn = 1'b1;

      // frame 1 plain, frame 2 via row wrap with stall,
      // then partial rows and a mid-frame sof resync
      add_frame(1'b1, 1'b0);
      add_frame(1'b0, 1'b1);
      for (int c = 0; c < W; c++) add_pix(0, c, 1'b0);
      for (int c = 0; c < 3; c++) add_pix(1, c, 1'b0);
      add_frame(1'b1, 1'b0);
      add_idle(3, 1'b0);

      for (int i = 0; i < vecs.size() + LAT - 1; i++) begin
         drive(i < vecs.size() ? vecs[i] : idle);
         @(posedge clk);
         #1;
         if (o_valid) n_v++;
         if (o_valid && o_eol) n_eol++;
         j = i - (LAT - 1);
         if (j >= 0) begin
            chk($sformatf("valid[%0d]", j),
                72'(o_valid), 72'(vecs[j].ev));
            if (vecs[j].ev) begin
               chk($sformatf("sof[%0d]", j),
                   72'(o_sof), 72'(vecs[j].esof));
               chk($sformatf("eol[%0d]", j),
                   72'(o_eol), 72'(vecs[j].eeol));
               chk($sformatf("win[%0d]", j),
                   o_win, vecs[j].ewin);
            end
            if (vecs[j].tag == 'h22)
               chk("win_first", o_win,
                   72'h22_21_20_12_11_10_02_01_00);
            if (vecs[j].tag == 'h23)
               chk("win_23", o_win,
                   72'h23_22_21_13_12_11_03_02_01);
            if (vecs[j].tag == 'h34)
               chk("w4_34", 72'(o_win[39:32]), 72'h23);
         end
      end
      chk("valid_count", 72'(n_v), 72'd18);
      chk("eol_count", 72'(n_eol), 72'd6);

      // async reset while a window is being presented
      seen = 1'b0;
      for (int k = 0; k < 3 * W + LAT + 2 && !seen; k++) begin
         if (k < 3 * W) add_pix(k / W, k % W, k == 0);
         drive(k < 3 * W ? vecs[vecs.size() - 1] : idle);
         @(posedge clk);
         #1;
         seen = o_valid;
      end
      chk("arst_pre_valid", 72'(seen), 72'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_valid", 72'(o_valid), 72'd0);
      chk("arst_win", o_win, 72'd0);
      chk("arst_sof", 72'(o_sof), 72'd0);
      drive(idle);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_arst_valid", 72'(o_valid), 72'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
